// File: rtl/fixed_pkg.sv
// Shared types and constant helpers for the sequential fixed-point units.
package fixed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Fixed-point 1.0 for a given fraction width.
  function automatic logic [127:0] one_const(int unsigned q);
    return 128'd1 << q;
  endfunction

  // Shift/compare iterations for an (n-1)-bit magnitude scaled up by q.
  function automatic int unsigned iters(int unsigned n, int unsigned q);
    return n - 1 + q;
  endfunction

  // Saturated magnitude (all ones below the sign bit) of an n-bit word.
  function automatic logic [127:0] sat_mag(int unsigned n);
    return (128'd1 << (n - 1)) - 128'd1;
  endfunction

endpackage

// File: rtl/fixed_div_seq_if.sv
// Operand/result handshake bundle for fixed_div_seq.
interface fixed_div_seq_if #(
  parameter int unsigned N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic         recip;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] q;
  logic         dbz;
  logic         ovf;

  modport master (
    output in_valid, recip, a, b, out_ready,
    input  in_ready, out_valid, q, dbz, ovf
  );

  modport slave (
    input  in_valid, recip, a, b, out_ready,
    output in_ready, out_valid, q, dbz, ovf
  );
endinterface

// File: rtl/fixed_div_seq.sv
// Sequential sign-magnitude fixed-point divider / reciprocal: radix-2 restoring,
// one quotient bit per cycle, with saturation, divide-by-zero and optional rounding.
module fixed_div_seq
  import fixed_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned Q     = 16,
  parameter int unsigned ROUND = 0
) (
  input logic            clk,
  input logic            rst_n,
  fixed_div_seq_if.slave bus
);

  localparam int unsigned ITERS = iters(N, Q);
  localparam int unsigned CW    = $clog2(ITERS);

  localparam logic [127:0]  OneWide = one_const(Q);
  localparam logic [127:0]  SatWide = sat_mag(N);
  localparam logic [N-2:0]  OneMag  = OneWide[N-2:0];
  localparam logic [N-2:0]  SatMag  = SatWide[N-2:0];
  localparam logic [CW-1:0] LastCnt = CW'(ITERS - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Dividend bits leave at the top while quotient bits enter at the bottom.
  logic [ITERS-1:0] dq_q, dq_d;
  logic [N-2:0]     rem_q, rem_d;
  logic [N-2:0]     mag_b_q, mag_b_d;
  logic             sign_q, sign_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     res_q, res_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [N-1:0]     rem_shift;
  logic             rem_ge;
  logic [N-1:0]     rem_new;
  logic [ITERS-1:0] quo_new;
  logic             rnd_up;
  logic [ITERS-1:0] quo_rnd;
  logic             sat;
  logic [N-2:0]     mag_fin;
  logic [N-2:0]     mag_a;

  always_comb begin
    rem_shift = {rem_q, dq_q[ITERS-1]};
    rem_ge    = rem_shift >= {1'b0, mag_b_q};
    rem_new   = rem_ge ? rem_shift - {1'b0, mag_b_q} : rem_shift;
    quo_new   = {dq_q[ITERS-2:0], rem_ge};
    rnd_up    = (ROUND != 0) && ({rem_new, 1'b0} >= {2'b00, mag_b_q});
    quo_rnd   = quo_new + {{(ITERS-1){1'b0}}, rnd_up};
    sat       = |quo_rnd[ITERS-1:N-1];
    mag_fin   = sat ? SatMag : quo_rnd[N-2:0];
    mag_a     = bus.recip ? OneMag : bus.a[N-2:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dq_d        = dq_q;
    rem_d       = rem_q;
    mag_b_d     = mag_b_q;
    sign_d      = sign_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mag_b_d = bus.b[N-2:0];
          sign_d  = bus.recip ? bus.b[N-1] : (bus.a[N-1] ^ bus.b[N-1]);
          cnt_d   = '0;
          rem_d   = '0;
          dq_d    = {mag_a, {Q{1'b0}}};
          state_d = CALC;
        end
      end
      CALC: begin
        // A zero divisor resolves on the first compute edge without iterating.
        if (mag_b_q == '0) begin
          res_d       = {sign_q, SatMag};
          dbz_d       = 1'b1;
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          dq_d  = quo_new;
          rem_d = rem_new[N-2:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            res_d       = {sign_q & (mag_fin != '0), mag_fin};
            dbz_d       = 1'b0;
            ovf_d       = sat;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dq_q        <= '0;
      rem_q       <= '0;
      mag_b_q     <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dq_q        <= dq_d;
      rem_q       <= rem_d;
      mag_b_q     <= mag_b_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.q         = res_q;
  assign bus.dbz       = dbz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fixed_div_seq.sv
// Self-checking bench: truncating and rounding instances driven in lockstep and
// compared against an arithmetic reference model.
module tb_fixed_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        recip = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fixed_div_seq_if #(.N(32)) bus0 ();
  fixed_div_seq_if #(.N(32)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.recip     = recip;
  assign bus0.a         = a;
  assign bus0.b         = b;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.recip     = recip;
  assign bus1.a         = a;
  assign bus1.b         = b;
  assign bus1.out_ready = out_ready;

  fixed_div_seq #(.N(32), .Q(16), .ROUND(0)) u_trunc (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fixed_div_seq #(.N(32), .Q(16), .ROUND(1)) u_round (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Returns {dbz, ovf, q} from plain integer division of Q16 sign-magnitude values.
  function automatic logic [33:0] model(logic [31:0] ma_in, logic [31:0] mb_in, logic rc,
                                        logic rnd);
    logic [63:0] ma, mb, num, quo, rem;
    logic        s;
    ma = rc ? 64'h10000 : {33'b0, ma_in[30:0]};
    mb = {33'b0, mb_in[30:0]};
    s  = rc ? mb_in[31] : (ma_in[31] ^ mb_in[31]);
    if (mb == 0) return {2'b10, s, 31'h7fffffff};
    num = ma << 16;
    quo = num / mb;
    rem = num % mb;
    if (rnd && (rem << 1) >= mb) quo = quo + 1;
    if (quo > 64'h7fffffff) return {2'b01, s, 31'h7fffffff};
    if (quo == 0) s = 1'b0;
    return {2'b00, s, quo[30:0]};
  endfunction

  task automatic do_op(input string name, input logic [31:0] oa, input logic [31:0] ob,
                       input logic orc, input logic early, input int exp_lat,
                       input logic [33:0] e0, input logic [33:0] e1);
    int lat;
    @(negedge clk);
    tests++;
    if ({bus0.in_ready, bus1.in_ready} !== 2'b11) begin
      fails++;
      $display("FAIL %s in_ready: got %b%b want 11", name, bus0.in_ready, bus1.in_ready);
    end
    in_valid  = 1'b1;
    a         = oa;
    b         = ob;
    recip     = orc;
    out_ready = early;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    lat      = 0;
    while (!bus0.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    tests++;
    if (lat !== exp_lat) begin
      fails++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    tests++;
    if (bus1.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s round out_valid: got %b want 1", name, bus1.out_valid);
    end
    tests++;
    if ({bus0.dbz, bus0.ovf, bus0.q} !== e0) begin
      fails++;
      $display("FAIL %s trunc: got dbz=%b ovf=%b q=%h want dbz=%b ovf=%b q=%h", name,
               bus0.dbz, bus0.ovf, bus0.q, e0[33], e0[32], e0[31:0]);
    end
    tests++;
    if ({bus1.dbz, bus1.ovf, bus1.q} !== e1) begin
      fails++;
      $display("FAIL %s round: got dbz=%b ovf=%b q=%h want dbz=%b ovf=%b q=%h", name,
               bus1.dbz, bus1.ovf, bus1.q, e1[33], e1[32], e1[31:0]);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests++;
    if ({bus0.out_valid, bus1.out_valid, bus0.in_ready, bus1.in_ready} !== 4'b0011) begin
      fails++;
      $display("FAIL %s drain: got v=%b%b r=%b%b want v=00 r=11", name, bus0.out_valid,
               bus1.out_valid, bus0.in_ready, bus1.in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus0.in_ready, bus0.out_valid, bus0.q, bus0.dbz, bus0.ovf} !== {2'b10, 32'h0, 2'b00}) begin
      fails++;
      $display("FAIL reset trunc: got r=%b v=%b q=%h dbz=%b ovf=%b want r=1 v=0 q=0 dbz=0 ovf=0",
               bus0.in_ready, bus0.out_valid, bus0.q, bus0.dbz, bus0.ovf);
    end
    tests++;
    if ({bus1.in_ready, bus1.out_valid, bus1.q, bus1.dbz, bus1.ovf} !== {2'b10, 32'h0, 2'b00}) begin
      fails++;
      $display("FAIL reset round: got r=%b v=%b q=%h dbz=%b ovf=%b want r=1 v=0 q=0 dbz=0 ovf=0",
               bus1.in_ready, bus1.out_valid, bus1.q, bus1.dbz, bus1.ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    do_op("div_6_2", 32'h00060000, 32'h00020000, 1'b0, 1'b0, 47,
          {2'b00, 32'h00030000}, {2'b00, 32'h00030000});
    do_op("neg_zero", 32'h80000000, 32'h00020000, 1'b0, 1'b1, 47,
          {2'b00, 32'h00000000}, {2'b00, 32'h00000000});
    do_op("neg_quarter", 32'h80010000, 32'h00040000, 1'b0, 1'b0, 47,
          {2'b00, 32'h80004000}, {2'b00, 32'h80004000});
    do_op("recip_neg6", 32'h12345678, 32'h80060000, 1'b1, 1'b0, 47,
          {2'b00, 32'h80002AAA}, {2'b00, 32'h80002AAB});
    do_op("div_zero", 32'h80050000, 32'h00000000, 1'b0, 1'b0, 1,
          {2'b10, 32'hFFFFFFFF}, {2'b10, 32'hFFFFFFFF});
    do_op("overflow", 32'h7FFF0000, 32'h00000100, 1'b0, 1'b1, 47,
          {2'b01, 32'h7FFFFFFF}, {2'b01, 32'h7FFFFFFF});
  endtask

  task automatic test_random;
    logic [31:0] oa, ob;
    logic        rc;
    for (int i = 0; i < 40; i++) begin
      oa = $urandom;
      ob = $urandom;
      rc = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: ob[30:20] = '0;
        1: oa[30:18] = '0;
        2: ob[30:0]  = '0;
        3: begin oa[30:22] = '0; ob[30:24] = '0; end
        default: ;
      endcase
      do_op("random", oa, ob, rc, 1'($urandom_range(0, 1)), (ob[30:0] == '0) ? 1 : 47,
            model(oa, ob, rc, 1'b0), model(oa, ob, rc, 1'b1));
    end
  endtask

  task automatic test_backpressure;
    int lat;
    int spurious;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'h00060000;
    b        = 32'h00020000;
    recip    = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 0;
    while (!bus0.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    tests++;
    if (lat !== 47) begin
      fails++;
      $display("FAIL bp latency: got %0d want 47", lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = $urandom;
      b        = $urandom;
      @(posedge clk);
      #1;
      tests++;
      if ({bus0.out_valid, bus0.in_ready, bus0.q, bus1.out_valid, bus1.in_ready, bus1.q} !==
          {2'b10, 32'h00030000, 2'b10, 32'h00030000}) begin
        fails++;
        $display("FAIL bp hold %0d: got v=%b r=%b q=%h / v=%b r=%b q=%h want v=1 r=0 q=00030000",
                 i, bus0.out_valid, bus0.in_ready, bus0.q, bus1.out_valid, bus1.in_ready, bus1.q);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    spurious  = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (bus0.out_valid || bus1.out_valid || !bus0.in_ready) spurious++;
    end
    tests++;
    if (spurious !== 0) begin
      fails++;
      $display("FAIL bp ignored_input: got %0d busy cycles want 0", spurious);
    end
  endtask

  task automatic test_reset_mid;
    int spurious;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'h00060000;
    b        = 32'h00020000;
    recip    = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({bus0.in_ready, bus0.out_valid, bus1.in_ready, bus1.out_valid} !== 4'b1010) begin
      fails++;
      $display("FAIL midreset state: got r=%b v=%b / r=%b v=%b want r=1 v=0", bus0.in_ready,
               bus0.out_valid, bus1.in_ready, bus1.out_valid);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    spurious = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (bus0.out_valid || bus1.out_valid) spurious++;
    end
    tests++;
    if (spurious !== 0) begin
      fails++;
      $display("FAIL midreset stale: got %0d valid cycles want 0", spurious);
    end
    do_op("after_reset", 32'h00090000, 32'h00030000, 1'b0, 1'b0, 47,
          {2'b00, 32'h00030000}, {2'b00, 32'h00030000});
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
